// File: rtl/counter_sched_pkg.sv
// Shared types and defaults for the counter scheduler.
// FSM states, default sizes, direction encodings, index-width helper.
package counter_sched_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } state_t;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_CNT_W   = 4;
    localparam int DEF_MAX_VAL = 15;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of one pending requester, searching upward from
// last_grant+1 (mod N_REQ).
// Ports: pending, last_grant, enable -> valid, win_idx (combinational).
module rr_arbiter
    import counter_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = idx_w(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [IDX_W-1:0] last_grant,
    input  logic             enable,
    output logic             valid,
    output logic [IDX_W-1:0] win_idx
);

    int               pos;
    logic [IDX_W-1:0] cand;
    logic             any;

    // Walk offsets from farthest to nearest so the nearest pending
    // index after last_grant is the one left standing.
    always_comb begin
        any     = 1'b0;
        win_idx = last_grant;
        pos     = 0;
        cand    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            pos  = (int'(last_grant) + k) % N_REQ;
            cand = IDX_W'(pos);
            if (pending[cand]) begin
                any     = 1'b1;
                win_idx = cand;
            end
        end
        valid = any & enable;
    end

endmodule

// File: rtl/counter_sched_ctrl.sv
// Shares one wrap/saturate counter between N_REQ edge-triggered requesters.
// Ports: clk, rst (sync, active-high), req_in, req_dir, enable, clr ->
//        cnt_out, grant (one-hot), tc_pulse, ovf (sticky), busy.
// Build option: define CNT_SAT_EN to saturate at 0/MAX_VAL instead of wrap.
module counter_sched_ctrl
    import counter_sched_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int MAX_VAL = DEF_MAX_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] req_dir,
    input  logic             enable,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_out,
    output logic [N_REQ-1:0] grant,
    output logic             tc_pulse,
    output logic             ovf,
    output logic             busy
);

    localparam int               IDX_W = idx_w(N_REQ);
    localparam logic [CNT_W-1:0] MAXV  = CNT_W'(MAX_VAL);

    state_t           state;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] last_grant;
    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] upd_mask;
    logic [N_REQ-1:0] pend_nxt;
    logic             lost;
    logic             arb_valid;
    logic [IDX_W-1:0] arb_idx;
    logic [CNT_W-1:0] cnt_upd;
    logic             at_bound;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .pending    (pending),
        .last_grant (last_grant),
        .enable     (enable),
        .valid      (arb_valid),
        .win_idx    (arb_idx)
    );

    assign rise     = req_in & ~req_q;
    assign busy     = (state == ST_UPDATE);
    assign upd_mask = busy ? (N_REQ'(1) << win_idx) : '0;
    assign grant    = upd_mask;

    // A new edge re-arms a bit even as it is being served.
    assign pend_nxt = (pending & ~upd_mask) | rise;
    assign lost     = |(rise & pending & ~upd_mask);

    always_comb begin
        cnt_upd  = cnt_out;
        at_bound = 1'b0;
        if (req_dir[win_idx] == DIR_UP) begin
            if (cnt_out == MAXV) begin
                at_bound = 1'b1;
`ifdef CNT_SAT_EN
                cnt_upd  = MAXV;
`else
                cnt_upd  = '0;
`endif
            end else begin
                cnt_upd = cnt_out + CNT_W'(1);
            end
        end else begin
            if (cnt_out == '0) begin
                at_bound = 1'b1;
`ifdef CNT_SAT_EN
                cnt_upd  = '0;
`else
                cnt_upd  = MAXV;
`endif
            end else begin
                cnt_upd = cnt_out - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            win_idx    <= '0;
            last_grant <= IDX_W'(N_REQ - 1);
            req_q      <= '0;
            pending    <= '0;
            cnt_out    <= '0;
            tc_pulse   <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            req_q    <= req_in;
            pending  <= pend_nxt;
            tc_pulse <= 1'b0;

            if (clr) begin
                ovf <= 1'b0;
            end else if (lost) begin
                ovf <= 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        win_idx <= arb_idx;
                        state   <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    last_grant <= win_idx;
                    state      <= ST_IDLE;
                    // clr wins the counter, but the request is consumed.
                    if (!clr) begin
                        cnt_out  <= cnt_upd;
                        tc_pulse <= at_bound;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (clr) begin
                cnt_out <= '0;
            end
        end
    end

endmodule
